// File: rtl/fb_sweep_issuer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fb_sweep_issuer_pkg
//  Purpose  : Shared opcodes, widths, screen defaults and sweep FSM encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package fb_sweep_issuer_pkg;

    localparam int c_opcode_width      = 3;
    localparam int c_instruction_width = 22;
    localparam int c_colour_width      = 3;
    localparam int c_screen_width      = 160;
    localparam int c_screen_height     = 120;

    localparam logic [c_opcode_width-1:0] c_opcode_draw    = 3'd1;
    localparam logic [c_opcode_width-1:0] c_opcode_display = 3'd2;

    // Field positions inside the instruction word
    localparam int c_x_lsb      = 0;
    localparam int c_y_lsb      = 8;
    localparam int c_colour_lsb = 15;
    localparam int c_we_bit     = 18;

    localparam int                 c_state_w    = 2;
    localparam logic [c_state_w-1:0] c_st_idle    = 2'd0;
    localparam logic [c_state_w-1:0] c_st_issue   = 2'd1;
    localparam logic [c_state_w-1:0] c_st_wait    = 2'd2;
    localparam logic [c_state_w-1:0] c_st_advance = 2'd3;

    // Counter width that never collapses to zero bits for a 1-wide axis
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_sweep_issuer_raster_counter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_sweep_issuer_raster_counter
//  Purpose  : Raster-order x/y pixel counter with clear, advance and last flag.
//  Revision : 1.0 - initial release
// ============================================================================
module fb_sweep_issuer_raster_counter
    import fb_sweep_issuer_pkg::*;
#(
    parameter int SCREEN_W = c_screen_width,
    parameter int SCREEN_H = c_screen_height,
    parameter int X_W      = clog2_min1(SCREEN_W),
    parameter int Y_W      = clog2_min1(SCREEN_H)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_clear,
    input  logic           i_advance,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last
);

    localparam logic [X_W-1:0] c_x_max = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] c_y_max = Y_W'(SCREEN_H - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    // Wrap against the real screen bounds, not the counter's natural overflow
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (r_x < c_x_max) begin
                r_x <= r_x + X_W'(1);
            end else begin
                r_x <= '0;
                r_y <= (r_y < c_y_max) ? r_y + Y_W'(1) : '0;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == c_x_max) && (r_y == c_y_max);

endmodule
`default_nettype wire

// File: rtl/fb_sweep_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : fb_sweep_issuer
//  Purpose  : Issues one datapath instruction per pixel for refresh/clear sweeps.
//  Revision : 1.0 - initial release
// ============================================================================
module fb_sweep_issuer
    import fb_sweep_issuer_pkg::*;
#(
    parameter int SCREEN_W = c_screen_width,
    parameter int SCREEN_H = c_screen_height,
    parameter int INSTR_W  = c_instruction_width
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      refresh_req,
    input  logic                      clear_req,
    input  logic [c_colour_width-1:0] clear_colour,
    input  logic                      dp_finished,
    output logic                      dp_start,
    output logic [INSTR_W-1:0]        dp_instruction,
    output logic                      busy,
    output logic                      sweep_done
);

    localparam int X_W = clog2_min1(SCREEN_W);
    localparam int Y_W = clog2_min1(SCREEN_H);

    logic [c_state_w-1:0]      r_state;
    logic                      r_pend_refresh;
    logic                      r_pend_clear;
    logic [c_colour_width-1:0] r_pend_colour;
    logic [c_colour_width-1:0] r_colour;
    logic                      r_is_clear;

    logic [X_W-1:0]            w_x;
    logic [Y_W-1:0]            w_y;
    logic                      w_last;
    logic                      w_start_clear;
    logic                      w_start_refresh;
    logic                      w_ctr_clear;
    logic                      w_ctr_advance;
    logic [INSTR_W-1:0]        w_instr;

    assign w_start_clear   = (r_state == c_st_idle) && r_pend_clear;
    assign w_start_refresh = (r_state == c_st_idle) && !r_pend_clear && r_pend_refresh;
    assign w_ctr_clear     = w_start_clear || w_start_refresh;
    assign w_ctr_advance   = (r_state == c_st_advance) && !w_last;

    fb_sweep_issuer_raster_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_raster_counter (
        .clk       (clock),
        .rst       (reset),
        .i_clear   (w_ctr_clear),
        .i_advance (w_ctr_advance),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_last    (w_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_pend_refresh <= 1'b0;
            r_pend_clear   <= 1'b0;
            r_pend_colour  <= '0;
            r_colour       <= '0;
            r_is_clear     <= 1'b0;
            dp_start       <= 1'b0;
            busy           <= 1'b0;
            sweep_done     <= 1'b0;
        end else begin
            // A request arriving on the start edge stays pending for the next sweep
            if (w_start_clear)   r_pend_clear   <= 1'b0;
            if (w_start_refresh) r_pend_refresh <= 1'b0;
            if (clear_req) begin
                r_pend_clear  <= 1'b1;
                r_pend_colour <= clear_colour;
            end
            if (refresh_req) r_pend_refresh <= 1'b1;

            sweep_done <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_start_clear || w_start_refresh) begin
                        r_is_clear <= w_start_clear;
                        if (w_start_clear) r_colour <= r_pend_colour;
                        dp_start <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= c_st_issue;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                c_st_issue: begin
                    if (dp_finished) begin
                        dp_start <= 1'b0;
                        r_state  <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (dp_finished) r_state <= c_st_advance;
                end
                c_st_advance: begin
                    if (w_last) begin
                        sweep_done <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= c_st_idle;
                    end else begin
                        dp_start <= 1'b1;
                        r_state  <= c_st_issue;
                    end
                end
                default: begin
                    dp_start <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= c_st_idle;
                end
            endcase
        end
    end

    // Built only from registered state, so it is steady for the whole ISSUE hold
    always_comb begin
        w_instr = '0;
        if (busy) begin
            w_instr[INSTR_W-1 -: c_opcode_width] = r_is_clear ? c_opcode_draw : c_opcode_display;
            w_instr[c_y_lsb +: 7]                = 7'(w_y);
            w_instr[c_x_lsb +: 8]                = 8'(w_x);
            if (r_is_clear) begin
                w_instr[c_we_bit]                         = 1'b1;
                w_instr[c_colour_lsb +: c_colour_width]   = r_colour;
            end
        end
    end

    assign dp_instruction = w_instr;

endmodule
`default_nettype wire

// File: tb/tb_fb_sweep_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_sweep_issuer
//  Purpose  : Self-checking bench for fb_sweep_issuer on a 4x3 screen.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fb_sweep_issuer;
    import fb_sweep_issuer_pkg::*;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int IW = c_instruction_width;

    logic                      clock        = 1'b0;
    logic                      reset        = 1'b1;
    logic                      refresh_req  = 1'b0;
    logic                      clear_req    = 1'b0;
    logic [c_colour_width-1:0] clear_colour = '0;
    logic                      dp_finished  = 1'b1;
    logic                      dp_start;
    logic [IW-1:0]             dp_instruction;
    logic                      busy;
    logic                      sweep_done;

    int vectors     = 0;
    int miscompares = 0;
    int accepts     = 0;
    int dones       = 0;

    logic [IW-1:0] exp_q[$];

    int resp_latency = 2;
    bit resp_random  = 1'b0;
    bit resp_hold    = 1'b0;
    int resp_cnt     = 0;

    fb_sweep_issuer #(
        .SCREEN_W (W),
        .SCREEN_H (H),
        .INSTR_W  (IW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .refresh_req    (refresh_req),
        .clear_req      (clear_req),
        .clear_colour   (clear_colour),
        .dp_finished    (dp_finished),
        .dp_start       (dp_start),
        .dp_instruction (dp_instruction),
        .busy           (busy),
        .sweep_done     (sweep_done)
    );

    always #5 clock = ~clock;

    // Instruction word from field values with plain arithmetic
    function automatic logic [IW-1:0] model_instr(bit is_clear, int col, int x, int y);
        longint v;
        v = (is_clear ? longint'(c_opcode_draw) : longint'(c_opcode_display)) * (longint'(1) << (IW - c_opcode_width));
        v = v + y * 256 + x;
        if (is_clear) v = v + (longint'(1) << 18) + col * (longint'(1) << 15);
        return IW'(v);
    endfunction

    task automatic expect_sweep(input bit is_clear, input int col);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back(model_instr(is_clear, col, x, y));
    endtask

    // Behavioural responder: accepts on start&finished, finishes after N cycles
    always @(posedge clock) begin
        if (dp_start && dp_finished) begin
            accepts++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL accept_unexpected: got %h, required no instruction", dp_instruction);
            end else begin
                if (dp_instruction !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL accept_instr: got %h, required %h", dp_instruction, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            dp_finished <= 1'b0;
            resp_cnt = resp_random ? int'($urandom_range(1, 4)) : resp_latency;
        end else if (resp_hold) begin
            dp_finished <= 1'b0;
        end else if (!dp_finished) begin
            if (resp_cnt <= 1) dp_finished <= 1'b1;
            else resp_cnt--;
        end
    end

    always @(negedge clock) if (sweep_done === 1'b1) dones++;

    task automatic pulse(input bit rf, input bit cl, input logic [c_colour_width-1:0] col);
        @(negedge clock);
        refresh_req  = rf;
        clear_req    = cl;
        clear_colour = col;
        @(negedge clock);
        refresh_req  = 1'b0;
        clear_req    = 1'b0;
        clear_colour = ~col;
    endtask

    task automatic wait_dones(input int target, input int budget, output bit timed_out);
        int n = 0;
        timed_out = 1'b0;
        while (dones < target) begin
            @(negedge clock);
            n++;
            if (n > budget) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        vectors++; if (dp_start !== 1'b0) begin miscompares++; $display("FAIL reset_dp_start: got %b, required 0", dp_start); end
        vectors++; if (dp_instruction !== '0) begin miscompares++; $display("FAIL reset_instr: got %h, required 0", dp_instruction); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
        vectors++; if (sweep_done !== 1'b0) begin miscompares++; $display("FAIL reset_sweep_done: got %b, required 0", sweep_done); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_refresh;
        int d0, a0;
        bit to;
        resp_random  = 1'b0;
        resp_latency = 2;
        d0 = dones; a0 = accepts;
        expect_sweep(1'b0, 0);
        pulse(1'b1, 1'b0, '0);
        @(negedge clock);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL refresh_busy_rise: got %b, required 1", busy); end
        vectors++; if (dp_instruction !== model_instr(1'b0, 0, 0, 0)) begin miscompares++; $display("FAIL refresh_first_instr: got %h, required %h", dp_instruction, model_instr(1'b0, 0, 0, 0)); end
        wait_dones(d0 + 1, 2000, to);
        vectors++; if (to) begin miscompares++; $display("FAIL refresh_timeout: got %0d sweeps, required %0d", dones - d0, 1); end
        @(negedge clock);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL refresh_busy_fall: got %b, required 0", busy); end
        vectors++; if (sweep_done !== 1'b0) begin miscompares++; $display("FAIL refresh_done_width: got %b, required 0", sweep_done); end
        repeat (40) @(negedge clock);
        vectors++; if (accepts - a0 !== 12) begin miscompares++; $display("FAIL refresh_count: got %0d, required 12", accepts - a0); end
        vectors++; if (dones - d0 !== 1) begin miscompares++; $display("FAIL refresh_dones: got %0d, required 1", dones - d0); end
    endtask

    task automatic test_clear;
        int d0, a0;
        bit to;
        logic [c_colour_width-1:0] col;
        resp_random = 1'b1;
        for (int it = 0; it < 2; it++) begin
            col = (it == 0) ? 3'b101 : c_colour_width'($urandom_range(0, 7));
            d0 = dones; a0 = accepts;
            expect_sweep(1'b1, int'(col));
            pulse(1'b0, 1'b1, col);
            wait_dones(d0 + 1, 2000, to);
            vectors++; if (to) begin miscompares++; $display("FAIL clear_timeout: got %0d sweeps, required 1", dones - d0); end
            repeat (40) @(negedge clock);
            vectors++; if (accepts - a0 !== 12) begin miscompares++; $display("FAIL clear_count: got %0d, required 12", accepts - a0); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_busy_end: got %b, required 0", busy); end
        end
    endtask

    task automatic test_both;
        int d0, a0;
        bit to;
        logic [c_colour_width-1:0] col;
        resp_random = 1'b1;
        col = c_colour_width'($urandom_range(0, 7));
        d0 = dones; a0 = accepts;
        expect_sweep(1'b1, int'(col));
        expect_sweep(1'b0, 0);
        pulse(1'b1, 1'b1, col);
        wait_dones(d0 + 2, 4000, to);
        vectors++; if (to) begin miscompares++; $display("FAIL both_timeout: got %0d sweeps, required 2", dones - d0); end
        repeat (60) @(negedge clock);
        vectors++; if (accepts - a0 !== 24) begin miscompares++; $display("FAIL both_count: got %0d, required 24", accepts - a0); end
        vectors++; if (dones - d0 !== 2) begin miscompares++; $display("FAIL both_dones: got %0d, required 2", dones - d0); end
    endtask

    task automatic test_stall;
        int d0, a0, n;
        bit to;
        resp_random  = 1'b0;
        resp_latency = 1;
        resp_hold    = 1'b1;
        d0 = dones; a0 = accepts;
        expect_sweep(1'b0, 0);
        pulse(1'b1, 1'b0, '0);
        n = 0;
        while (dp_start !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        vectors++; if (dp_start !== 1'b1) begin miscompares++; $display("FAIL stall_start: got %b, required 1", dp_start); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            vectors++; if (dp_start !== 1'b1 || dp_instruction !== model_instr(1'b0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL stall_hold: got start=%b instr=%h, required start=1 instr=%h", dp_start, dp_instruction, model_instr(1'b0, 0, 0, 0));
            end
        end
        vectors++; if (accepts !== a0) begin miscompares++; $display("FAIL stall_early_accept: got %0d, required %0d", accepts - a0, 0); end
        resp_hold = 1'b0;
        wait_dones(d0 + 1, 2000, to);
        vectors++; if (to) begin miscompares++; $display("FAIL stall_timeout: got %0d sweeps, required 1", dones - d0); end
        repeat (40) @(negedge clock);
        vectors++; if (accepts - a0 !== 12) begin miscompares++; $display("FAIL stall_count: got %0d, required 12", accepts - a0); end
    endtask

    task automatic test_reset_mid;
        int d0, n;
        bit to;
        resp_random = 1'b1;
        expect_sweep(1'b0, 0);
        pulse(1'b1, 1'b0, '0);
        n = 0;
        while (!(dp_start === 1'b1 && dp_instruction === model_instr(1'b0, 0, 2, 1)) && n < 2000) begin
            @(negedge clock); n++;
        end
        vectors++; if (n >= 2000) begin miscompares++; $display("FAIL midreset_reach: got %h, required %h", dp_instruction, model_instr(1'b0, 0, 2, 1)); end
        d0 = dones;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        vectors++; if (dp_start !== 1'b0) begin miscompares++; $display("FAIL midreset_start: got %b, required 0", dp_start); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b, required 0", busy); end
        repeat (20) @(negedge clock);
        vectors++; if (dones !== d0) begin miscompares++; $display("FAIL midreset_no_done: got %0d, required %0d", dones - d0, 0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_idle: got %b, required 0", busy); end
        expect_sweep(1'b0, 0);
        pulse(1'b1, 1'b0, '0);
        wait_dones(d0 + 1, 2000, to);
        vectors++; if (to) begin miscompares++; $display("FAIL midreset_restart: got %0d sweeps, required 1", dones - d0); end
        repeat (40) @(negedge clock);
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL midreset_left: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_repeat;
        int d0, a0;
        bit to;
        resp_random = 1'b1;
        d0 = dones; a0 = accepts;
        expect_sweep(1'b0, 0);
        expect_sweep(1'b0, 0);
        pulse(1'b1, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            repeat (int'($urandom_range(3, 8))) @(negedge clock);
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL repeat_busy: got %b, required 1", busy); end
            pulse(1'b1, 1'b0, '0);
        end
        wait_dones(d0 + 2, 4000, to);
        vectors++; if (to) begin miscompares++; $display("FAIL repeat_timeout: got %0d sweeps, required 2", dones - d0); end
        repeat (100) @(negedge clock);
        vectors++; if (accepts - a0 !== 24) begin miscompares++; $display("FAIL repeat_count: got %0d, required 24", accepts - a0); end
        vectors++; if (dones - d0 !== 2) begin miscompares++; $display("FAIL repeat_dones: got %0d, required 2", dones - d0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL repeat_idle: got %b, required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_refresh();
        test_clear();
        test_both();
        test_stall();
        test_reset_mid();
        test_repeat();
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
